// File: rtl/lu_block_sched_if.sv
// Dispatch and handshake bundle between the LU block scheduler and its environment.
// The master side is the scheduler. The slave side is the start/CPU-completion environment.
interface lu_block_sched_if #(
  parameter int N_CPU = 4,
  parameter int NB_W  = 3
);
  logic             i_start;
  logic [NB_W:0]    i_nblocks;
  logic             o_busy;
  logic             o_done;
  logic [NB_W-1:0]  o_kb;
  logic [N_CPU-1:0] o_go;
  logic [1:0]       o_mode;
  logic [NB_W-1:0]  o_row;
  logic [NB_W-1:0]  o_col;
  logic             o_whichpage;
  logic             o_flush;
  logic [N_CPU-1:0] i_done;

  modport master (
    input  i_start, i_nblocks, i_done,
    output o_busy, o_done, o_kb, o_go, o_mode, o_row, o_col, o_whichpage, o_flush
  );

  modport slave (
    output i_start, i_nblocks, i_done,
    input  o_busy, o_done, o_kb, o_go, o_mode, o_row, o_col, o_whichpage, o_flush
  );
endinterface

// File: rtl/lu_block_sched.sv
// Blocked-LU outer-step scheduler: walks the NB x NB block grid per kb step and
// dispatches diagonal, panel and trailing blocks to N_CPU pipelines behind kb barriers.
module lu_block_sched #(
  parameter int N_CPU = 4,
  parameter int NB_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  lu_block_sched_if.master bus
);
  localparam int               CW       = NB_W + 1;
  localparam logic [CW-1:0]    NB_MAX   = {1'b1, {NB_W{1'b0}}};
  localparam logic [N_CPU-1:0] ONE_CPU0 = N_CPU'(1);
  localparam logic [1:0] MODE_1 = 2'd0, MODE_2 = 2'd1, MODE_3 = 2'd2, MODE_4 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_A, S_A_WAIT, S_B, S_B_WAIT, S_C, S_C_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    nb_q, nb_n, kb_q, kb_n, r_q, r_n, c_q, c_n, ti_q, ti_n, tj_q, tj_n;
  logic [CW-1:0]    kb1;
  logic [N_CPU-1:0] busy_q, page_q, busy_eff;
  logic [N_CPU-1:0] pick_any, pick_b, row_pick, go;
  logic [1:0]       mode;
  logic [CW-1:0]    row, col;
  logic             flush, done;

  assign kb1      = kb_q + 1'b1;
  // A done arriving this cycle already opens a barrier; it only frees the CPU for dispatch next cycle.
  assign busy_eff = busy_q & ~bus.i_done;

  always_comb begin
    pick_any = '0;
    pick_b   = '0;
    for (int k = N_CPU - 1; k >= 0; k--)
      if (!busy_q[k]) begin
        pick_any    = '0;
        pick_any[k] = 1'b1;
      end
    for (int k = N_CPU - 1; k >= 1; k--)
      if (!busy_q[k]) begin
        pick_b    = '0;
        pick_b[k] = 1'b1;
      end
    if (N_CPU > 1) row_pick = pick_b;
    else           row_pick = (r_q >= nb_q) ? pick_any : '0;
  end

  always_comb begin
    state_n = state_q;
    nb_n    = nb_q;
    kb_n    = kb_q;
    r_n     = r_q;
    c_n     = c_q;
    ti_n    = ti_q;
    tj_n    = tj_q;
    go      = '0;
    mode    = MODE_1;
    row     = '0;
    col     = '0;
    flush   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.i_start) begin
        nb_n    = (bus.i_nblocks > NB_MAX) ? NB_MAX : bus.i_nblocks;
        kb_n    = '0;
        state_n = (bus.i_nblocks == '0) ? S_DONE : S_A;
      end
      S_A: if (!busy_q[0]) begin
        go      = ONE_CPU0;
        mode    = MODE_1;
        row     = kb_q;
        col     = kb_q;
        flush   = 1'b1;
        state_n = S_A_WAIT;
      end
      S_A_WAIT: if (busy_eff == '0) begin
        if (kb1 < nb_q) begin
          r_n     = kb1;
          c_n     = kb1;
          state_n = S_B;
        end else begin
          state_n = S_DONE;
        end
      end
      S_B: begin
        // Column (MODE_2) has priority: it is tied to the single BPU.
        if (r_q >= nb_q && c_q >= nb_q) begin
          state_n = S_B_WAIT;
        end else if (r_q < nb_q && !busy_q[0]) begin
          go    = ONE_CPU0;
          mode  = MODE_2;
          row   = r_q;
          col   = kb_q;
          flush = 1'b1;
          r_n   = r_q + 1'b1;
        end else if (c_q < nb_q && (|row_pick)) begin
          go    = row_pick;
          mode  = MODE_3;
          row   = kb_q;
          col   = c_q;
          flush = 1'b1;
          c_n   = c_q + 1'b1;
        end
      end
      S_B_WAIT: if (busy_eff == '0) begin
        ti_n    = kb1;
        tj_n    = kb1;
        state_n = S_C;
      end
      S_C: begin
        if (ti_q >= nb_q) begin
          state_n = S_C_WAIT;
        end else if (|pick_any) begin
          go    = pick_any;
          mode  = MODE_4;
          row   = ti_q;
          col   = tj_q;
          flush = (ti_q == kb1) || (tj_q == kb1);
          if (tj_q + 1'b1 >= nb_q) begin
            tj_n = kb1;
            ti_n = ti_q + 1'b1;
          end else begin
            tj_n = tj_q + 1'b1;
          end
        end
      end
      S_C_WAIT: if (busy_eff == '0) begin
        kb_n    = kb1;
        state_n = S_A;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      nb_q    <= '0;
      kb_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ti_q    <= '0;
      tj_q    <= '0;
      busy_q  <= '0;
      page_q  <= '0;
    end else begin
      state_q <= state_n;
      nb_q    <= nb_n;
      kb_q    <= kb_n;
      r_q     <= r_n;
      c_q     <= c_n;
      ti_q    <= ti_n;
      tj_q    <= tj_n;
      busy_q  <= busy_eff | go;
      page_q  <= page_q ^ go;
    end
  end

  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_done      = done;
  assign bus.o_kb        = kb_q[NB_W-1:0];
  assign bus.o_go        = go;
  assign bus.o_mode      = mode;
  assign bus.o_row       = row[NB_W-1:0];
  assign bus.o_col       = col[NB_W-1:0];
  assign bus.o_whichpage = |(go & page_q);
  assign bus.o_flush     = flush;
endmodule

// File: tb/tb_lu_block_sched.sv
// Bench for lu_block_sched: job table over NB / CPU count / latency, a rule-based dispatch
// reference with randomized CPU completion latencies, plus barrier, restart and reset sequences.
module tb_lu_block_sched;
  localparam int NB_W = 3;

  typedef struct { int phase; int mode; int row; int col; bit flush; } disp_t;
  typedef struct { bit sel; int nb; int lo; int hi; int exp_disp; bit hold; bit poke; } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lu_block_sched_if #(.N_CPU(4), .NB_W(NB_W)) bus4 ();
  lu_block_sched_if #(.N_CPU(1), .NB_W(NB_W)) bus1 ();
  lu_block_sched #(.N_CPU(4), .NB_W(NB_W)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  lu_block_sched #(.N_CPU(1), .NB_W(NB_W)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic            sel, start_d;
  logic [NB_W:0]   nb_d;
  logic [3:0]      done_drv;

  assign bus4.i_start   = start_d & ~sel;
  assign bus4.i_nblocks = nb_d;
  assign bus4.i_done    = sel ? 4'b0000 : done_drv;
  assign bus1.i_start   = start_d & sel;
  assign bus1.i_nblocks = nb_d;
  assign bus1.i_done    = sel ? done_drv[0:0] : 1'b0;

  logic [3:0]      go_s;
  logic [1:0]      mode_s;
  logic [NB_W-1:0] row_s, col_s, kb_s;
  logic            page_s, flush_s, done_s, busy_s;

  always_comb begin
    if (sel) begin
      go_s = {3'b000, bus1.o_go}; mode_s = bus1.o_mode; row_s = bus1.o_row; col_s = bus1.o_col;
      kb_s = bus1.o_kb; page_s = bus1.o_whichpage; flush_s = bus1.o_flush;
      done_s = bus1.o_done; busy_s = bus1.o_busy;
    end else begin
      go_s = bus4.o_go; mode_s = bus4.o_mode; row_s = bus4.o_row; col_s = bus4.o_col;
      kb_s = bus4.o_kb; page_s = bus4.o_whichpage; flush_s = bus4.o_flush;
      done_s = bus4.o_done; busy_s = bus4.o_busy;
    end
  end

  disp_t      exp_q[$];
  vec_t       tab[9];
  logic [3:0] mbusy;
  logic [3:0] mpage [2];
  int         due[4];
  int n_vec = 0, n_err = 0;
  int cyc = 0, n_cpu, lat_lo, lat_hi;
  int n_disp, n_done, done_cyc, first_go, last_phase, last_drv, m1_expect;
  bit hold_armed, hold_hit;

  task automatic chk(bit ok, string name, int act, int req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expected dispatch set: each phase (kb*3 + A/B/C) must drain before the next one starts.
  task automatic build(int nb);
    exp_q.delete();
    for (int kb = 0; kb < nb; kb++) begin
      exp_q.push_back('{kb*3, 0, kb, kb, 1'b1});
      if (kb < nb - 1) begin
        for (int r = kb + 1; r < nb; r++) exp_q.push_back('{kb*3+1, 1, r, kb, 1'b1});
        for (int c = kb + 1; c < nb; c++) exp_q.push_back('{kb*3+1, 2, kb, c, 1'b1});
        for (int i = kb + 1; i < nb; i++)
          for (int j = kb + 1; j < nb; j++)
            exp_q.push_back('{kb*3+2, 3, i, j, (i == kb+1) || (j == kb+1)});
      end
    end
  endtask

  function automatic int lowest(int lo, int hi);
    int r = -1;
    for (int c = hi; c >= lo; c--) if (!mbusy[c]) r = c;
    return r;
  endfunction

  task automatic step();
    int cpu, idx, exp_cpu;
    bit ok, pend_m2;
    string req;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 4; c++) if (done_drv[c]) mbusy[c] = 1'b0;
    if (done_s) begin n_done++; done_cyc = cyc; end
    if (go_s == 4'b0000) begin
      chk({mode_s, row_s, col_s, page_s, flush_s} == '0, "idle_fields",
          int'({mode_s, row_s, col_s, page_s, flush_s}), 0);
    end else begin
      n_disp++;
      if (first_go < 0) first_go = cyc;
      cpu = 0;
      for (int c = 0; c < 4; c++) if (go_s[c]) cpu = c;
      idx = -1;
      for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].mode == int'(mode_s)) idx = k;
      pend_m2 = 1'b0;
      for (int k = 0; k < exp_q.size(); k++)
        if (exp_q[k].mode == 1 && exp_q[k].phase == exp_q[0].phase) pend_m2 = 1'b1;
      case (int'(mode_s))
        0, 1:    exp_cpu = mbusy[0] ? -1 : 0;
        2:       exp_cpu = (n_cpu > 1) ? lowest(1, n_cpu - 1) : lowest(0, 0);
        default: exp_cpu = lowest(0, n_cpu - 1);
      endcase
      ok = $onehot(go_s) && idx >= 0 && cpu == exp_cpu;
      if (ok) ok = exp_q[idx].phase == exp_q[0].phase && exp_q[idx].row == int'(row_s) &&
                   exp_q[idx].col == int'(col_s) && exp_q[idx].flush == flush_s &&
                   exp_q[idx].phase / 3 == int'(kb_s) && page_s == mpage[sel][cpu];
      if (ok && exp_q[idx].phase != last_phase) ok = (mbusy == 4'b0000);
      if (ok && int'(mode_s) == 2 && pend_m2 && (n_cpu == 1 || !mbusy[0])) ok = 1'b0;
      if (idx >= 0)
        req = $sformatf("cpu%0d mode %0d (%0d,%0d) flush %0d page %0d kb %0d", exp_cpu,
                        exp_q[idx].mode, exp_q[idx].row, exp_q[idx].col, exp_q[idx].flush,
                        mpage[sel][cpu], exp_q[idx].phase / 3);
      else
        req = "no such dispatch pending";
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL dispatch @%0d: got go %b mode %0d (%0d,%0d) flush %0d page %0d kb %0d; required %s",
                 cyc, go_s, mode_s, row_s, col_s, flush_s, page_s, kb_s, req);
      end
      if (idx >= 0) begin
        last_phase = exp_q[idx].phase;
        exp_q.delete(idx);
      end
      mbusy[cpu] = 1'b1;
      mpage[sel][cpu] = ~mpage[sel][cpu];
      due[cpu] = cyc + lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
      if (hold_armed && int'(mode_s) == 3 && cpu == 3 && int'(kb_s) == 0) begin
        due[3] = cyc + 50;
        m1_expect = cyc + 51;
        hold_armed = 1'b0;
      end
      if (m1_expect > 0 && int'(mode_s) == 0 && int'(kb_s) == 1) begin
        chk(cyc == m1_expect, "barrier_mode1_cycle", cyc, m1_expect);
        m1_expect = 0;
        hold_hit = 1'b1;
      end
    end
    for (int c = 0; c < 4; c++) begin
      done_drv[c] = (due[c] == cyc);
      if (done_drv[c]) begin due[c] = -1; last_drv = cyc; end
    end
  endtask

  task automatic run_job(vec_t v);
    int start_cyc, nb;
    nb = (v.nb > 8) ? 8 : v.nb;
    sel = v.sel; n_cpu = v.sel ? 1 : 4; lat_lo = v.lo; lat_hi = v.hi;
    build(nb);
    n_disp = 0; n_done = 0; done_cyc = -1; first_go = -1; last_phase = -1; last_drv = -1;
    hold_armed = v.hold; hold_hit = 1'b0; m1_expect = 0;
    step();
    start_d = 1'b1; nb_d = (NB_W+1)'(v.nb); start_cyc = cyc;
    while (n_done == 0 && cyc < start_cyc + 6000) begin
      step();
      start_d = v.poke && (cyc == start_cyc + 6);
      if (start_d) nb_d = (NB_W+1)'(1);
      if (cyc == start_cyc + 1) chk(busy_s == 1'b1, "busy_after_start", int'(busy_s), 1);
    end
    repeat (3) begin
      step();
      if (cyc == done_cyc + 1) chk(busy_s == 1'b0, "busy_after_done", int'(busy_s), 0);
    end
    chk(n_done == 1, "done_pulses", n_done, 1);
    chk(exp_q.size() == 0, "dispatches_missing", exp_q.size(), 0);
    chk(n_disp == v.exp_disp, "dispatch_total", n_disp, v.exp_disp);
    if (nb == 0) chk(done_cyc == start_cyc + 1, "done_latency_nb0", done_cyc, start_cyc + 1);
    else begin
      chk(first_go == start_cyc + 1, "first_go_cycle", first_go, start_cyc + 1);
      chk(done_cyc == last_drv + 1, "done_after_last_cpu", done_cyc, last_drv + 1);
    end
    if (v.hold) chk(hold_hit, "barrier_hold_seen", int'(hold_hit), 1);
  endtask

  initial begin
    bit seen;
    tab[0] = '{1'b0, 1,  10, 10, 1,   1'b0, 1'b0};
    tab[1] = '{1'b1, 2,  1,  4,  5,   1'b0, 1'b0};
    tab[2] = '{1'b0, 3,  5,  5,  14,  1'b1, 1'b0};
    tab[3] = '{1'b0, 0,  1,  1,  0,   1'b0, 1'b0};
    tab[4] = '{1'b0, 15, 1,  6,  204, 1'b0, 1'b0};
    tab[5] = '{1'b0, 2,  1,  6,  5,   1'b0, 1'b0};
    tab[6] = '{1'b1, 3,  1,  3,  14,  1'b0, 1'b0};
    tab[7] = '{1'b0, 5,  2,  7,  55,  1'b0, 1'b0};
    tab[8] = '{1'b0, 3,  5,  5,  14,  1'b0, 1'b1};
    start_d = 1'b0; nb_d = '0; done_drv = 4'b0000; sel = 1'b0;
    mbusy = 4'b0000; mpage[0] = 4'b0000; mpage[1] = 4'b0000;
    for (int c = 0; c < 4; c++) due[c] = -1;
    n_cpu = 4; lat_lo = 1; lat_hi = 1; last_phase = -1; m1_expect = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    step(); step();
    #1;
    chk({bus4.o_busy, bus4.o_done, bus4.o_go, bus4.o_mode, bus4.o_row, bus4.o_col,
         bus4.o_kb, bus4.o_whichpage, bus4.o_flush} == '0, "reset_outputs_cpu4", int'(bus4.o_go), 0);
    chk({bus1.o_busy, bus1.o_done, bus1.o_go, bus1.o_mode, bus1.o_row, bus1.o_col,
         bus1.o_kb, bus1.o_whichpage, bus1.o_flush} == '0, "reset_outputs_cpu1", int'(bus1.o_go), 0);
    reset = 1'b0;

    // Stray completion for an idle CPU must not mark it busy.
    step();
    done_drv[2] = 1'b1;
    repeat (3) step();

    foreach (tab[i]) run_job(tab[i]);

    // Reset in the middle of the panel phase, then a fresh single-block job.
    sel = 1'b0; n_cpu = 4; lat_lo = 5; lat_hi = 5; build(3);
    last_phase = -1; hold_armed = 1'b0; m1_expect = 0; first_go = -1;
    step(); start_d = 1'b1; nb_d = (NB_W+1)'(3);
    step(); start_d = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (go_s != 4'b0000 && mode_s == 2'd1) seen = 1'b1;
    end
    chk(seen, "reached_panel_phase", int'(seen), 1);
    reset = 1'b1;
    #1;
    chk({bus4.o_busy, bus4.o_done, bus4.o_go, bus4.o_mode, bus4.o_row, bus4.o_col,
         bus4.o_kb, bus4.o_whichpage, bus4.o_flush} == '0, "midrun_reset_outputs", int'(bus4.o_go), 0);
    mbusy = 4'b0000; mpage[0] = 4'b0000; mpage[1] = 4'b0000; exp_q.delete();
    step(); step();
    reset = 1'b0;
    repeat (8) step();
    run_job(tab[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
